// File: rtl/kbd_pkg.sv
// Shared definitions for the keystroke FIFO: size defaults, producer FSM
// encoding and address-width derivation.
package kbd_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } prod_state_t;

  // Pointer width for a power-of-two FIFO depth.
  function automatic int unsigned addr_w_f(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/kbd_fifo_sync_rise.sv
// sync_rise: two-flop synchroniser for an asynchronous level followed by a
// rising-edge detector.
//   clk       : sampling clock
//   rst       : asynchronous active-high reset
//   i_async   : asynchronous level input
//   o_pulse_c : one-cycle pulse (decode of flops) per synchronised rise
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse_c
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchroniser chain plus the previous-value flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse_c = r_sync2 & ~r_prev;

endmodule

// File: rtl/kbd_fifo.sv
// kbd_fifo: keystroke buffer between the PS/2 driver and the CPU keyboard
// interrupt port. Captures codes over a req/ack handshake, holds up to DEPTH
// of them, and shows the oldest code with a level interrupt.
//   clk, rst  : clock, asynchronous active-high reset
//   in_req    : driver request level, in_data : key code
//   in_ack    : one-cycle acknowledge to the driver
//   out_int   : FIFO non-empty, out_data : head entry (0 when empty)
//   out_ack   : asynchronous acknowledge level; each rise pops one entry
//   flush     : synchronous clear
//   count     : entries held, overflow : sticky key-dropped flag
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = addr_w_f(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_req,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ack,
  output logic              out_int,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ack,
  input  logic              flush,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  prod_state_t       r_state;
  prod_state_t       w_state_nxt;
  logic              w_capture;
  logic              w_ack_nxt;
  logic              w_pop;
  logic              w_pop_eff;
  logic              w_push;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_in_ack;
  logic [DATA_W-1:0] r_mem [DEPTH];

  sync_rise u_ack_sync (
    .clk       (clk),
    .rst       (rst),
    .i_async   (out_ack),
    .o_pulse_c (w_pop)
  );

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Producer state register; reset lands in WAIT_LOW so a held request is
  // not re-captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_WAIT_LOW;
    else     r_state <= w_state_nxt;
  end

  // Producer next state.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_WAIT_LOW;
    end else begin
      unique case (r_state)
        ST_IDLE:     if (in_req) w_state_nxt = ST_ACK;
        ST_ACK:      w_state_nxt = ST_WAIT_LOW;
        ST_WAIT_LOW: if (!in_req) w_state_nxt = ST_IDLE;
        default:     w_state_nxt = ST_WAIT_LOW;
      endcase
    end
  end

  // Producer outputs: capture strobe and the value loaded into the ack flop.
  always_comb begin
    w_capture = 1'b0;
    w_ack_nxt = 1'b0;
    if (r_state == ST_IDLE && in_req && !flush) w_capture = 1'b1;
    if (w_state_nxt == ST_ACK) w_ack_nxt = 1'b1;
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a key.
  assign w_pop_eff = w_pop && !w_empty && !flush;
  assign w_push    = w_capture && (!w_full || w_pop_eff);
  assign w_drop    = w_capture && !w_push;

  // Pointers, occupancy, sticky overflow and the ack pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_in_ack   <= 1'b0;
    end else begin
      r_in_ack <= w_ack_nxt;
      if (flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push)    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (w_pop_eff) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        if (w_push && !w_pop_eff)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop_eff) r_count <= r_count - CNT_W'(1);
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  assign in_ack   = r_in_ack;
  assign out_int  = !w_empty;
  assign out_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: doc/kbd_fifo.md
# kbd_fifo

Keystroke buffer between the PS/2 keyboard driver (`ps2_drv`) and the CPU system's keyboard interrupt port. It accepts ASCII codes from the driver over a req/ack handshake, stores up to DEPTH codes, and presents the oldest code plus a level interrupt to the system. The system's `kbd_int_ack` arrives from the slow, separately divided CPU clock, so the block treats it as an asynchronous level and acts on its synchronised rising edge. Keys typed while the CPU is slow or single-stepped are buffered instead of lost.

## Interface
- `DATA_W`, default 8: keystroke code width.
- `DEPTH`, default 16: entries; must be a power of 2, minimum 2.
- `ADDR_W`, default 4: log2(DEPTH).
- `clk` in 1: clk50M domain; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_req` in 1: driver `int_req`; level, held high until acknowledged.
- `in_data` in DATA_W: driver `kbd_ascii`; stable while `in_req` is high.
- `in_ack` out 1: to driver `int_ack`; one-cycle pulse.
- `out_int` out 1: to system `kbd_int`; high while the FIFO is non-empty.
- `out_data` out DATA_W: to system `kbd_data`; head entry, 0 when empty.
- `out_ack` in 1: from system `kbd_int_ack`; asynchronous level; each rising edge pops one entry.
- `flush` in 1: synchronous clear.
- `count` out ADDR_W+1: entries held, 0..DEPTH.
- `overflow` out 1: sticky; set when a key is dropped because the FIFO is full.

## Operation
- Storage: DEPTH x DATA_W array. `wr_ptr` and `rd_ptr` are ADDR_W bits and wrap modulo DEPTH. `count` is a separate register. `full` = (count==DEPTH). `empty` = (count==0).
- Producer FSM, three states:
  - IDLE: if `in_req`=1, go to ACK. In that same transition, push `in_data` if not full, or if full and a pop happens in the same cycle. Otherwise drop the key and set `overflow`.
  - ACK: `in_ack`=1 for exactly this cycle; go to WAIT_LOW.
  - WAIT_LOW: stay until `in_req`=0, then go to IDLE. Prevents double capture of one key.
- Consumer path:
  - `out_ack` passes through a 2-flop synchroniser, then a rise detector (third flop). A detected rise is `pop`.
  - `pop` when empty is ignored; `count` never underflows.
- Push and pop in the same cycle: both pointers advance and `count` is unchanged. This also applies when full.
- `out_int` = !empty, driven from the `count` register; it is not a separate flop.
- `out_data` = empty ? 0 : mem[rd_ptr], i.e. show-ahead.
- `flush`: pointers, `count` and `overflow` go to 0 and the FSM goes to WAIT_LOW. Synchroniser flops are preserved. `flush` takes priority over push and pop in the same cycle.
- Reset values: FSM=WAIT_LOW, pointers=0, count=0, `overflow`=0, `in_ack`=0, `out_int`=0, `out_data`=0, synchroniser flops=0. Memory contents are not reset.
- Reset mid-handshake: the FSM restarts in WAIT_LOW, so a key already being offered with `in_req` held high is not re-captured after reset.

## Timing
- Push latency: `in_req` sampled high at edge N → entry written at edge N, `out_int`/`count` update after edge N, `in_ack` high during cycle N+1.
- Back-to-back keys: at least 3 cycles per key (IDLE → ACK → WAIT_LOW → IDLE), plus the driver's time to drop `in_req`.
- Pop latency: `out_ack` rises before edge M → sync1 at M, sync2 at M+1, `pop` at M+2. After edge M+2, `out_data` shows the next entry and `count` has decremented.
- `out_ack` must stay high at least 2 clk cycles and low at least 2 clk cycles between pops. Shorter pulses may be missed; there is no other constraint.
- All outputs are glitch-free registered or simple decode of registers. `out_data` is a read mux from memory, stable while `rd_ptr` is stable.

## Structure
- Shared package `kbd_pkg` holds:
  - the `DATA_W` and `DEPTH` defaults;
  - the producer FSM state encoding (IDLE=2'd0, ACK=2'd1, WAIT_LOW=2'd2);
  - a function for `ADDR_W` derivation (clog2).
- One sub-module, `sync_rise`: 2-flop synchroniser plus rise detector. It has its own `clk` and `rst`, 1-bit async input, 1-cycle pulse output. `kbd_fifo` instantiates it for `out_ack`.
- The remainder is the single `kbd_fifo` module: FSM, pointers, count, memory.

## Test plan
- Reset then one key: `in_req`=1 with `in_data`=8'h41 → one `in_ack` pulse, `out_int`=1, `out_data`=8'h41, `count`=1. Then toggle `out_ack` 0→1 → 3 cycles later `out_int`=0, `out_data`=0, `count`=0.
- Order and wrap: push 8'h30..8'h3F (16 keys, FIFO full), pop 8, push 8'h40..8'h47, pop all 16 → pops return 8'h38..8'h3F then 8'h40..8'h47; `overflow`=0.
- Overflow: full FIFO, then push 8'h55 → `in_ack` still pulses, the key is dropped, `overflow`=1, `count`=16, head unchanged. Then `flush` → `count`=0, `overflow`=0, `out_int`=0.
- Simultaneous push and pop at `count`=16: align the `pop` cycle with the IDLE capture → key accepted, `count` stays 16, `overflow`=0.
- Held request and short ack: hold `in_req` high for 20 cycles → exactly one push. Pulse `out_ack` high for 1 cycle with `count`=2 → no pop guaranteed, `count` ≥ 1. Pop on empty → `count` stays 0.
- Async reset asserted during ACK with `in_req` still high → outputs go to reset values immediately. After release, no capture until `in_req` drops and rises again.
